// File: rtl/alu_share_ctrl.sv
// Shares one 4-bit ALU between two requesters with round-robin arbitration.
// Optional macro ALU_SHARE_ZERO_FLAG_EN adds a registered rsp_zero output.
module alu_share_ctrl #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_op_a,
  input  logic [3:0] req0_op_b,
  input  logic [3:0] req0_inst,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_op_a,
  input  logic [3:0] req1_op_b,
  input  logic [3:0] req1_inst,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
`ifdef ALU_SHARE_ZERO_FLAG_EN
  output logic       rsp_zero,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PTR_INIT = (RR_INIT != 0);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [3:0] inst_q, inst_d;
  logic       id_q, id_d;
  logic [3:0] rsp_data_q, rsp_data_d;
`ifdef ALU_SHARE_ZERO_FLAG_EN
  logic       rsp_zero_q, rsp_zero_d;
`endif

  logic       gnt0, gnt1;
  logic [3:0] alu_res;
  logic [3:0] logic_res;

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~ptr_q);
    gnt1 = req1_valid & (~req0_valid |  ptr_q);
  end

  // Readies are additionally gated by reset so they read 0 while reset is held.
  always_comb begin
    req0_ready = reset & (state_q == IDLE) & gnt0;
    req1_ready = reset & (state_q == IDLE) & gnt1;
  end

  always_comb begin
    logic_res = '0;
    case (inst_q[2:1])
      2'b00:   logic_res = '0;
      2'b01:   logic_res = op_a_q & op_b_q;
      2'b10:   logic_res = op_a_q | op_b_q;
      default: logic_res = op_a_q ^ op_b_q;
    endcase
    if (inst_q[0]) begin
      logic_res = ~logic_res;
    end
  end

  always_comb begin
    alu_res = '0;
    if (!inst_q[3]) begin
      alu_res = logic_res;
    end else begin
      case (inst_q[2:0])
        3'b000:  alu_res = op_a_q;
        3'b001:  alu_res = ~op_a_q;
        3'b010:  alu_res = op_a_q + 4'd1;
        3'b011:  alu_res = op_a_q - 4'd1;
        3'b100:  alu_res = op_a_q + op_b_q;
        3'b101:  alu_res = op_a_q - op_b_q;
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    inst_d     = inst_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
`ifdef ALU_SHARE_ZERO_FLAG_EN
    rsp_zero_d = rsp_zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = EXEC;
          id_d    = gnt1;
          op_a_d  = gnt1 ? req1_op_a : req0_op_a;
          op_b_d  = gnt1 ? req1_op_b : req0_op_b;
          inst_d  = gnt1 ? req1_inst : req0_inst;
        end
      end
      EXEC: begin
        state_d    = RESP;
        rsp_data_d = alu_res;
`ifdef ALU_SHARE_ZERO_FLAG_EN
        rsp_zero_d = (alu_res == 4'b0000);
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_INIT;
      op_a_q     <= '0;
      op_b_q     <= '0;
      inst_q     <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
`ifdef ALU_SHARE_ZERO_FLAG_EN
      rsp_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      inst_q     <= inst_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
`ifdef ALU_SHARE_ZERO_FLAG_EN
      rsp_zero_q <= rsp_zero_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = (state_q == RESP);
    rsp_id    = id_q;
    rsp_data  = rsp_data_q;
    busy      = (state_q != IDLE);
  end

`ifdef ALU_SHARE_ZERO_FLAG_EN
  assign rsp_zero = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl (RR_INIT=0).
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_op_a, req0_op_b, req0_inst;
  logic [3:0] req1_op_a, req1_op_b, req1_inst;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_data;
`ifdef ALU_SHARE_ZERO_FLAG_EN
  logic       rsp_zero;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.RR_INIT(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op_a  (req0_op_a),
    .req0_op_b  (req0_op_b),
    .req0_inst  (req0_inst),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op_a  (req1_op_a),
    .req1_op_b  (req1_op_b),
    .req1_inst  (req1_inst),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
`ifdef ALU_SHARE_ZERO_FLAG_EN
    .rsp_zero   (rsp_zero),
`endif
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op_a  = 4'd3; req0_op_b = 4'd4; req0_inst = 4'hC;
    req1_op_a  = 4'd6; req1_op_b = 4'd1; req1_inst = 4'hC;
    rsp_ready  = 1'b1;

    // Reset held with both valid high
    tick(); tick(); tick();
    chk("rst_r0", {3'b0, req0_ready}, 4'd0);
    chk("rst_r1", {3'b0, req1_ready}, 4'd0);
    chk("rst_vld", {3'b0, rsp_valid}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_data", rsp_data, 4'd0);
    chk("rst_id", {3'b0, rsp_id}, 4'd0);
`ifdef ALU_SHARE_ZERO_FLAG_EN
    chk("rst_zero", {3'b0, rsp_zero}, 4'd0);
`endif

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_busy", {3'b0, busy}, 4'd0);

    // Single request: 5+3 = 8
    req0_valid = 1'b1; req0_op_a = 4'd5; req0_op_b = 4'd3; req0_inst = 4'b1100;
    #1;
    chk("s_r0", {3'b0, req0_ready}, 4'd1);
    chk("s_r1", {3'b0, req1_ready}, 4'd0);
    tick();
    req0_valid = 1'b0; req0_op_a = 4'hF; req0_op_b = 4'hF; req0_inst = 4'h0;
    chk("s_exec_vld", {3'b0, rsp_valid}, 4'd0);
    chk("s_exec_busy", {3'b0, busy}, 4'd1);
    tick();
    chk("s_vld", {3'b0, rsp_valid}, 4'd1);
    chk("s_id", {3'b0, rsp_id}, 4'd0);
    chk("s_data", rsp_data, 4'd8);
    tick();
    chk("s_done_vld", {3'b0, rsp_valid}, 4'd0);
    chk("s_done_busy", {3'b0, busy}, 4'd0);

    // Pointer moved to 1 above; reset restores RR_INIT=0 before contention
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();

    // Contention: req0 12&10 = 8, req1 2-5 = 13
    req0_valid = 1'b1; req0_op_a = 4'd12; req0_op_b = 4'd10; req0_inst = 4'b0010;
    req1_valid = 1'b1; req1_op_a = 4'd2;  req1_op_b = 4'd5;  req1_inst = 4'b1101;
    #1;
    chk("c1_r0", {3'b0, req0_ready}, 4'd1);
    chk("c1_r1", {3'b0, req1_ready}, 4'd0);
    tick();
    tick();
    chk("c1_vld", {3'b0, rsp_valid}, 4'd1);
    chk("c1_id", {3'b0, rsp_id}, 4'd0);
    chk("c1_data", rsp_data, 4'd8);
    chk("c1_pend_r1", {3'b0, req1_ready}, 4'd0);
    tick();
    chk("c2_r0", {3'b0, req0_ready}, 4'd0);
    chk("c2_r1", {3'b0, req1_ready}, 4'd1);
    tick();
    tick();
    chk("c2_vld", {3'b0, rsp_valid}, 4'd1);
    chk("c2_id", {3'b0, rsp_id}, 4'd1);
    chk("c2_data", rsp_data, 4'd13);
    tick();
    chk("c3_r0", {3'b0, req0_ready}, 4'd1);
    chk("c3_r1", {3'b0, req1_ready}, 4'd0);

    // Backpressure on the third operation (req0 again, 8)
    rsp_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_vld", {3'b0, rsp_valid}, 4'd1);
      chk("bp_id", {3'b0, rsp_id}, 4'd0);
      chk("bp_data", rsp_data, 4'd8);
      chk("bp_r0", {3'b0, req0_ready}, 4'd0);
      chk("bp_r1", {3'b0, req1_ready}, 4'd0);
      chk("bp_busy", {3'b0, busy}, 4'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tick();
    chk("bp_next_r1", {3'b0, req1_ready}, 4'd1);

    // Accept req1, then reset while in EXEC
    tick();
    chk("mr_exec_busy", {3'b0, busy}, 4'd1);
    reset = 1'b0;
    #1;
    chk("mr_busy", {3'b0, busy}, 4'd0);
    chk("mr_vld", {3'b0, rsp_valid}, 4'd0);
    chk("mr_r0", {3'b0, req0_ready}, 4'd0);
    chk("mr_r1", {3'b0, req1_ready}, 4'd0);
    tick();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", {3'b0, rsp_valid}, 4'd0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mr_gnt_r0", {3'b0, req0_ready}, 4'd1);
    chk("mr_gnt_r1", {3'b0, req1_ready}, 4'd0);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    chk("mr_after_vld", {3'b0, busy}, 4'd0);

    // A-1 with A=1 gives zero; ~(1^1) gives 15
    req0_valid = 1'b1; req0_op_a = 4'd1; req0_op_b = 4'd0; req0_inst = 4'b1011;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("z1_data", rsp_data, 4'd0);
`ifdef ALU_SHARE_ZERO_FLAG_EN
    chk("z1_zero", {3'b0, rsp_zero}, 4'd1);
`endif
    tick();
    req0_valid = 1'b1; req0_op_a = 4'd1; req0_op_b = 4'd1; req0_inst = 4'b0111;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("z2_data", rsp_data, 4'd15);
`ifdef ALU_SHARE_ZERO_FLAG_EN
    chk("z2_zero", {3'b0, rsp_zero}, 4'd0);
`endif
    tick();

    // Remaining arithmetic decodes via req1: ~A, A+1 wrap, reserved code
    req1_valid = 1'b1; req1_op_a = 4'd5; req1_op_b = 4'd0; req1_inst = 4'b1001;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("na_id", {3'b0, rsp_id}, 4'd1);
    chk("na_data", rsp_data, 4'd10);
    tick();
    req1_valid = 1'b1; req1_op_a = 4'd15; req1_inst = 4'b1010;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("inc_data", rsp_data, 4'd0);
    tick();
    req1_valid = 1'b1; req1_op_a = 4'd9; req1_op_b = 4'd3; req1_inst = 4'b1110;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("rsv_data", rsp_data, 4'd0);
    tick();
    req1_valid = 1'b1; req1_op_a = 4'd9; req1_op_b = 4'd3; req1_inst = 4'b0101;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("nor_data", rsp_data, 4'd4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
